// File: rtl/nvdla_mcif_arb_pkg.sv
// Shared definitions for the MCIF read-request weighted round-robin arbiter:
// FSM state encoding, counter/weight widths and the effective-weight helper.
package nvdla_mcif_arb_pkg;

    // Arbiter FSM: ARB grants from credits, REFILL reloads every credit.
    typedef enum logic [0:0] {
        ST_ARB    = 1'b0,
        ST_REFILL = 1'b1
    } arb_state_e;

    // Outstanding counter must hold 0..256 inclusive.
    localparam int OS_CNT_W = 9;

    // Per-client weight and credit width.
    localparam int WEIGHT_W = 8;

    // A programmed weight of zero still earns one grant per refill round,
    // so a misprogrammed client can never starve.
    function automatic logic [WEIGHT_W-1:0] w_eff(input logic [WEIGHT_W-1:0] w);
        return (w == 8'd0) ? 8'd1 : w;
    endfunction

endpackage

// File: rtl/nvdla_mcif_rr_pick.sv
// Rotating-priority picker: returns the first set bit of the eligible vector
// searching upward from ptr and wrapping around.
module nvdla_mcif_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  eligible_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_oh_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic          gnt_any_o
);

    logic [IW-1:0] cand_s;

    // Walk the N candidates in rotating order and keep the first eligible one.
    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        gnt_any_o = 1'b0;
        cand_s    = '0;
        for (int k = 0; k < N; k++) begin
            cand_s = IW'((int'(ptr_i) + k) % N);
            if (!gnt_any_o && eligible_i[cand_s]) begin
                gnt_any_o        = 1'b1;
                gnt_idx_o        = cand_s;
                gnt_oh_o[cand_s] = 1'b1;
            end else begin
                gnt_any_o = gnt_any_o;
            end
        end
    end

endmodule

// File: rtl/nvdla_mcif_rd_wrr_arb.sv
// Weighted round-robin read-request arbiter for the MCIF read path.
// Clients spend one credit per grant; when every requesting client is out of
// credit the FSM spends one REFILL cycle reloading credits from the weights.
// An outstanding-request counter throttles grants against reg2dp_rd_os_cnt+1.
module nvdla_mcif_rd_wrr_arb
    import nvdla_mcif_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int PD_WIDTH    = 79,
    parameter int ID_WIDTH    = 2
) (
    input  logic                            nvdla_core_clk,
    input  logic                            nvdla_core_rstn,
    input  logic [7:0]                      reg2dp_rd_os_cnt,
    input  logic [8*NUM_CLIENTS-1:0]        reg2dp_rd_weight,
    input  logic [NUM_CLIENTS-1:0]          clt_req_valid,
    output logic [NUM_CLIENTS-1:0]          clt_req_ready,
    input  logic [PD_WIDTH*NUM_CLIENTS-1:0] clt_req_pd,
    output logic                            arb_req_valid,
    input  logic                            arb_req_ready,
    output logic [PD_WIDTH-1:0]             arb_req_pd,
    output logic [ID_WIDTH-1:0]             arb_req_id,
    input  logic                            rd_done,
    output logic [OS_CNT_W-1:0]             os_cnt,
    output logic                            arb_idle
);

    arb_state_e              state_q, state_d;
    logic [WEIGHT_W-1:0]     cr_q [NUM_CLIENTS];
    logic [WEIGHT_W-1:0]     cr_d [NUM_CLIENTS];
    logic [ID_WIDTH-1:0]     ptr_q, ptr_d;
    logic [OS_CNT_W-1:0]     os_cnt_q, os_cnt_d;
    logic                    arb_valid_q, arb_valid_d;
    logic [PD_WIDTH-1:0]     arb_pd_q, arb_pd_d;
    logic [ID_WIDTH-1:0]     arb_id_q, arb_id_d;

    logic [NUM_CLIENTS-1:0]  eligible_s;
    logic [NUM_CLIENTS-1:0]  gnt_oh_s;
    logic [ID_WIDTH-1:0]     gnt_idx_s;
    logic                    gnt_any_s;
    logic                    slot_free_s;
    logic                    os_ok_s;
    logic                    arb_open_s;
    logic                    grant_s;
    logic                    gnt_last_cr_s;
    logic                    os_dec_s;

    // A client may compete only while it is requesting and still holds credit.
    always_comb begin
        eligible_s = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            eligible_s[i] = clt_req_valid[i] & (cr_q[i] != 8'd0);
        end
    end

    nvdla_mcif_rr_pick #(
        .N  (NUM_CLIENTS),
        .IW (ID_WIDTH)
    ) u_pick (
        .eligible_i (eligible_s),
        .ptr_i      (ptr_q),
        .gnt_oh_o   (gnt_oh_s),
        .gnt_idx_o  (gnt_idx_s),
        .gnt_any_o  (gnt_any_s)
    );

    // Grant qualification: output slot drains this cycle and the registered
    // outstanding count is below the programmed limit.
    always_comb begin
        slot_free_s   = ~arb_valid_q | arb_req_ready;
        os_ok_s       = (os_cnt_q < ({1'b0, reg2dp_rd_os_cnt} + 9'd1));
        arb_open_s    = (state_q == ST_ARB) & slot_free_s & os_ok_s;
        grant_s       = arb_open_s & gnt_any_s;
        clt_req_ready = grant_s ? gnt_oh_s : '0;
        gnt_last_cr_s = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            gnt_last_cr_s = gnt_last_cr_s | (gnt_oh_s[i] & (cr_q[i] == 8'd1));
        end
    end

    // Next state: fall into REFILL when requests exist but none has credit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARB: begin
                if (arb_open_s && (|clt_req_valid) && !(|eligible_s)) begin
                    state_d = ST_REFILL;
                end else begin
                    state_d = ST_ARB;
                end
            end
            ST_REFILL: state_d = ST_ARB;
            default:   state_d = ST_ARB;
        endcase
    end

    // Credits reload in REFILL, otherwise the granted client spends one.
    always_comb begin
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            cr_d[i] = cr_q[i];
        end
        if (state_q == ST_REFILL) begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                cr_d[i] = w_eff(reg2dp_rd_weight[8*i +: 8]);
            end
        end else if (grant_s) begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                if (gnt_oh_s[i]) begin
                    cr_d[i] = cr_q[i] - 8'd1;
                end else begin
                    cr_d[i] = cr_q[i];
                end
            end
        end else begin
            cr_d[0] = cr_q[0];
        end
    end

    // Pointer stays on the granted client while it has credit left, giving
    // back-to-back bursts of length weight before rotating.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_s && gnt_last_cr_s) begin
            if (gnt_idx_s == ID_WIDTH'(NUM_CLIENTS - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx_s + ID_WIDTH'(1);
            end
        end else if (grant_s) begin
            ptr_d = gnt_idx_s;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Outstanding count: up on grant, down on rd_done, cancel when both.
    always_comb begin
        os_dec_s = rd_done & (os_cnt_q != 9'd0);
        case ({grant_s, os_dec_s})
            2'b10:   os_cnt_d = os_cnt_q + 9'd1;
            2'b01:   os_cnt_d = os_cnt_q - 9'd1;
            default: os_cnt_d = os_cnt_q;
        endcase
    end

    // Output register: load on grant, clear valid on drain, else hold.
    always_comb begin
        arb_pd_d    = arb_pd_q;
        arb_id_d    = arb_id_q;
        arb_valid_d = arb_valid_q;
        if (grant_s) begin
            arb_valid_d = 1'b1;
            arb_pd_d    = clt_req_pd[PD_WIDTH*gnt_idx_s +: PD_WIDTH];
            arb_id_d    = gnt_idx_s;
        end else if (arb_req_ready) begin
            arb_valid_d = 1'b0;
        end else begin
            arb_valid_d = arb_valid_q;
        end
    end

    // State, credit, pointer, counter and output registers.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q     <= ST_ARB;
            ptr_q       <= '0;
            os_cnt_q    <= 9'd0;
            arb_valid_q <= 1'b0;
            arb_pd_q    <= '0;
            arb_id_q    <= '0;
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                cr_q[i] <= 8'd0;
            end
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            os_cnt_q    <= os_cnt_d;
            arb_valid_q <= arb_valid_d;
            arb_pd_q    <= arb_pd_d;
            arb_id_q    <= arb_id_d;
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                cr_q[i] <= cr_d[i];
            end
        end
    end

    assign arb_req_valid = arb_valid_q;
    assign arb_req_pd    = arb_pd_q;
    assign arb_req_id    = arb_id_q;
    assign os_cnt        = os_cnt_q;
    assign arb_idle      = (os_cnt_q == 9'd0) & ~arb_valid_q & ~(|clt_req_valid);

endmodule

// File: tb/tb_nvdla_mcif_rd_wrr_arb.sv
// Self-checking bench for nvdla_mcif_rd_wrr_arb: directed scenarios plus a
// randomized phase, all compared cycle by cycle against a behavioural model.
module tb_nvdla_mcif_rd_wrr_arb;

    localparam int N  = 4;
    localparam int PW = 79;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [7:0]      os_lim;
    logic [8*N-1:0]  wt;
    logic [N-1:0]    cv;
    logic [N-1:0]    c_rdy;
    logic [PW*N-1:0] cpd;
    logic            av;
    logic            ar;
    logic [PW-1:0]   apd;
    logic [IW-1:0]   aid;
    logic            done;
    logic [8:0]      osc;
    logic            idle;

    int compared = 0;
    int mism     = 0;

    // behavioural model state
    bit            m_valid;
    logic [PW-1:0] m_pd;
    int            m_id;
    int            m_os;
    int            m_cr[N];
    int            m_ptr;
    bit            m_refill;
    int            m_g;
    bit            m_goref;

    // grants observed on the DUT
    int dut_grants;
    int dut_gid_q[$];
    bit saw_rdy;

    nvdla_mcif_rd_wrr_arb #(.NUM_CLIENTS(N), .PD_WIDTH(PW), .ID_WIDTH(IW)) dut (
        .nvdla_core_clk   (clk),
        .nvdla_core_rstn  (rst_n),
        .reg2dp_rd_os_cnt (os_lim),
        .reg2dp_rd_weight (wt),
        .clt_req_valid    (cv),
        .clt_req_ready    (c_rdy),
        .clt_req_pd       (cpd),
        .arb_req_valid    (av),
        .arb_req_ready    (ar),
        .arb_req_pd       (apd),
        .arb_req_id       (aid),
        .rd_done          (done),
        .os_cnt           (osc),
        .arb_idle         (idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] rand_pd();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[PW-1:0];
    endfunction

    function automatic int weff(input int i);
        int w;
        w = int'(wt[8*i +: 8]);
        return (w == 0) ? 1 : w;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_pd = '0; m_id = 0; m_os = 0; m_ptr = 0; m_refill = 1'b0;
        for (int i = 0; i < N; i++) m_cr[i] = 0;
    endtask

    // Decide this cycle's grant from the rules: rotating search from ptr
    // among requesting clients with credit, gated by slot and limit.
    task automatic model_comb();
        bit slot, ok;
        int idx;
        slot = !m_valid || ar;
        ok   = m_os < int'(os_lim) + 1;
        m_g = -1;
        m_goref = 1'b0;
        if (!m_refill && slot && ok) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (m_g < 0 && cv[idx] && m_cr[idx] != 0) m_g = idx;
            end
            if (m_g < 0 && cv != '0) m_goref = 1'b1;
        end
    endtask

    task automatic model_seq();
        bit dec;
        dec = done && (m_os > 0);
        if (m_refill) begin
            for (int i = 0; i < N; i++) m_cr[i] = weff(i);
            m_refill = 1'b0;
        end else if (m_goref) begin
            m_refill = 1'b1;
        end
        if (m_g >= 0) begin
            m_valid = 1'b1;
            m_pd    = cpd[PW*m_g +: PW];
            m_id    = m_g;
            m_cr[m_g] = m_cr[m_g] - 1;
            m_ptr   = (m_cr[m_g] != 0) ? m_g : (m_g + 1) % N;
        end else if (ar) begin
            m_valid = 1'b0;
        end
        if (m_g >= 0 && !dec) m_os = m_os + 1;
        else if (m_g < 0 && dec) m_os = m_os - 1;
    endtask

    // One clock: called at a negedge with inputs already driven.
    task automatic cycle();
        logic [N-1:0] e;
        #1;
        model_comb();
        e = '0;
        if (m_g >= 0) e[m_g] = 1'b1;
        chk("clt_req_ready", 128'(c_rdy), 128'(e));
        chk("arb_idle", 128'(idle), 128'((m_os == 0) && !m_valid && (cv == '0)));
        saw_rdy = (c_rdy != '0);
        @(posedge clk);
        #1;
        model_seq();
        if (saw_rdy) begin
            dut_grants++;
            dut_gid_q.push_back(int'(aid));
        end
        chk("arb_req_valid", 128'(av), 128'(m_valid));
        chk("arb_req_id", 128'(aid), 128'(m_id[IW-1:0]));
        chk("arb_req_pd", 128'(apd), 128'(m_pd));
        chk("os_cnt", 128'(osc), 128'(m_os));
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cv    = '0;
        done  = 1'b0;
        ar    = 1'b1;
        #1;
        model_reset();
        chk("rst_valid", 128'(av), 128'(0));
        chk("rst_pd", 128'(apd), 128'(0));
        chk("rst_id", 128'(aid), 128'(0));
        chk("rst_os_cnt", 128'(osc), 128'(0));
        chk("rst_ready", 128'(c_rdy), 128'(0));
        chk("rst_idle", 128'(idle), 128'(1));
        @(negedge clk);
        rst_n = 1'b1;
        dut_grants = 0;
        dut_gid_q.delete();
    endtask

    initial begin
        int pat[8];
        int g0;
        logic [PW-1:0] hold_pd;
        logic [IW-1:0] hold_id;
        int bound;

        rst_n = 1'b0; os_lim = 8'd255; wt = '0; cv = '0; done = 1'b0; ar = 1'b1;
        for (int i = 0; i < N; i++) cpd[PW*i +: PW] = rand_pd();
        @(negedge clk);
        do_reset();

        // Weights {3,1}: burst of three from client 0 then one from client 1.
        wt = {8'd1, 8'd1, 8'd1, 8'd3};
        cv = 4'b0011;
        for (int c = 0; c < 24; c++) begin
            for (int i = 0; i < N; i++) cpd[PW*i +: PW] = rand_pd();
            cycle();
        end
        pat = '{0, 0, 0, 1, 0, 0, 0, 1};
        chk("wrr_count", 128'(dut_gid_q.size() >= 8), 128'(1));
        for (int i = 0; i < 8 && i < dut_gid_q.size(); i++) chk("wrr_seq", 128'(dut_gid_q[i]), 128'(pat[i]));

        // Outstanding limit of 2 with no completions.
        @(negedge clk);
        do_reset();
        os_lim = 8'd1;
        wt = {8'd1, 8'd1, 8'd1, 8'd8};
        cv = 4'b0001;
        run(10);
        chk("os_limit_grants", 128'(dut_grants), 128'(2));
        chk("os_limit_cnt", 128'(osc), 128'(2));
        chk("os_limit_ready", 128'(c_rdy), 128'(0));
        done = 1'b1;
        cycle();
        done = 1'b0;
        run(5);
        chk("os_done_grants", 128'(dut_grants), 128'(3));
        chk("os_done_cnt", 128'(osc), 128'(2));

        // Downstream back-pressure: output must hold.
        do_reset();
        os_lim = 8'd255;
        cv = 4'b0001;
        run(4);
        chk("bp_valid", 128'(av), 128'(1));
        hold_pd = apd;
        hold_id = aid;
        ar = 1'b0;
        g0 = int'(osc);
        for (int c = 0; c < 5; c++) begin
            cpd[0 +: PW] = rand_pd();
            cycle();
            chk("bp_pd_stable", 128'(apd), 128'(hold_pd));
            chk("bp_id_stable", 128'(aid), 128'(hold_id));
            chk("bp_os_stable", 128'(osc), 128'(g0));
        end
        ar = 1'b1;
        run(2);

        // Grant and completion together at os_cnt 4.
        do_reset();
        cv = 4'b0001;
        bound = 0;
        while (m_os < 4 && bound < 20) begin cycle(); bound++; end
        chk("reach_os4", 128'(osc), 128'(4));
        g0 = dut_grants;
        done = 1'b1;
        cycle();
        done = 1'b0;
        chk("simul_grant", 128'(dut_grants), 128'(g0 + 1));
        chk("simul_os", 128'(osc), 128'(4));

        // Weight 0 client alone: one grant per refill round.
        do_reset();
        wt = '0;
        cv = 4'b0100;
        run(12);
        chk("w0_grants", 128'(dut_grants), 128'(4));
        for (int i = 0; i < dut_gid_q.size(); i++) chk("w0_id", 128'(dut_gid_q[i]), 128'(2));

        // Randomized traffic with changing weights and limits.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            cv = N'($urandom_range(0, 15));
            ar = ($urandom_range(0, 3) != 0);
            done = (m_os > 0) && ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 19) == 0) os_lim = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 29) == 0) begin
                for (int i = 0; i < N; i++) wt[8*i +: 8] = 8'($urandom_range(0, 3));
            end
            for (int i = 0; i < N; i++) cpd[PW*i +: PW] = rand_pd();
            cycle();
        end
        done = 1'b0;

        // Asynchronous reset mid-stream at os_cnt 7.
        do_reset();
        os_lim = 8'd255;
        wt = {8'd1, 8'd1, 8'd2, 8'd2};
        cv = 4'b0011;
        bound = 0;
        while (m_os < 7 && bound < 30) begin cycle(); bound++; end
        chk("reach_os7", 128'(osc), 128'(7));
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_valid", 128'(av), 128'(0));
        chk("mid_rst_pd", 128'(apd), 128'(0));
        chk("mid_rst_id", 128'(aid), 128'(0));
        chk("mid_rst_os", 128'(osc), 128'(0));
        chk("mid_rst_ready", 128'(c_rdy), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        cv = 4'b0001;
        dut_grants = 0;
        run(2);
        chk("post_rst_no_grant", 128'(dut_grants), 128'(0));
        cycle();
        chk("post_rst_grant_t2", 128'(dut_grants), 128'(1));
        run(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
